// File: rtl/serial_tx_dev.sv
// Write-only UART-style (8N1) transmitter behind the bridge: CPU pushes bytes into a small
// FIFO, an FSM shifts them out LSB-first. Optional parity frame via SERIAL_TX_PARITY_EN.
module serial_tx_dev #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        txd,
  output logic        irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Bridge handshake: a register access is a single-cycle strobe (we=1 for one clk);
  // there is no back-pressure, so a push into a full FIFO is dropped and flagged in OVF.

  logic             en_q;
  logic             irqen_q;
  logic             pen_q;
  logic             odd_q;
  logic             ovf_q;
  logic [DIV_W-1:0] baud_q;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] bit_cnt;
  logic [7:0]       shift_q;
  logic [2:0]       bit_idx;
  logic             par_q;
  logic             frame_pen;
  logic             txd_q;
  logic             irq_q;

  logic             wr_ctrl;
  logic             wr_data;
  logic             wr_baud;
  logic             empty;
  logic             full;
  logic             busy;
  logic             bit_end;
  logic             pop;
  logic             push_ok;
  logic [7:0]       head;
  logic             unused_wd;

  assign wr_ctrl = we && (addr == 2'd0);
  assign wr_data = we && (addr == 2'd2);
  assign wr_baud = we && (addr == 2'd3);

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign busy    = (state != S_IDLE);
  assign bit_end = (bit_cnt == '0);
  assign head    = mem[rd_ptr];

  // A new frame starts from IDLE, or straight out of the last STOP cycle so frames abut.
  assign pop     = en_q && !empty &&
                   ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign push_ok = wr_data && (!full || pop);

  assign unused_wd = ^wd[31:DIV_W];

  // Control, baud and overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b0;
      irqen_q <= 1'b0;
      ovf_q   <= 1'b0;
      baud_q  <= DIV_W'(DEFAULT_DIV);
    end else begin
      if (wr_ctrl) begin
        en_q    <= wd[0];
        irqen_q <= wd[1];
      end
      if (wr_baud) begin
        baud_q <= wd[DIV_W-1:0];
      end
      if (wr_ctrl) begin
        ovf_q <= 1'b0;
      end else if (wr_data && !push_ok) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pen_q <= 1'b0;
      odd_q <= 1'b0;
    end else if (wr_ctrl) begin
      pen_q <= wd[2];
      odd_q <= wd[3];
    end
  end
`else
  assign pen_q = 1'b0;
  assign odd_q = 1'b0;
`endif

  // FIFO storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wd[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Transmit FSM; div_q freezes the bit period for the whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      txd_q     <= 1'b1;
      div_q     <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      bit_idx   <= '0;
      par_q     <= 1'b0;
      frame_pen <= 1'b0;
    end else if (pop) begin
      state     <= S_START;
      txd_q     <= 1'b0;
      shift_q   <= head;
      div_q     <= baud_q;
      bit_cnt   <= baud_q;
      bit_idx   <= '0;
      par_q     <= (^head) ^ odd_q;
      frame_pen <= pen_q;
    end else begin
      case (state)
        S_IDLE: begin
          txd_q <= 1'b1;
        end
        S_START: begin
          if (!bit_end) begin
            bit_cnt <= bit_cnt - DIV_W'(1);
          end else begin
            state   <= S_DATA;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_idx <= '0;
            bit_cnt <= div_q;
          end
        end
        S_DATA: begin
          if (!bit_end) begin
            bit_cnt <= bit_cnt - DIV_W'(1);
          end else begin
            bit_cnt <= div_q;
            if (bit_idx == 3'd7) begin
              if (frame_pen) begin
                state <= S_PARITY;
                txd_q <= par_q;
              end else begin
                state <= S_STOP;
                txd_q <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        S_PARITY: begin
          if (!bit_end) begin
            bit_cnt <= bit_cnt - DIV_W'(1);
          end else begin
            state   <= S_STOP;
            txd_q   <= 1'b1;
            bit_cnt <= div_q;
          end
        end
        S_STOP: begin
          if (!bit_end) begin
            bit_cnt <= bit_cnt - DIV_W'(1);
          end else begin
            state <= S_IDLE;
            txd_q <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          txd_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irqen_q && en_q && empty && !busy;
    end
  end

  assign txd = txd_q;
  assign irq = irq_q;

  always_comb begin
    rd = '0;
    case (addr)
      2'd0: begin
        rd[0] = en_q;
        rd[1] = irqen_q;
        rd[2] = pen_q;
        rd[3] = odd_q;
      end
      2'd1: begin
        rd[0]   = busy;
        rd[1]   = full;
        rd[2]   = empty;
        rd[3]   = ovf_q;
        rd[7:4] = 4'(count);
      end
      2'd3: begin
        rd[DIV_W-1:0] = baud_q;
      end
      default: begin
        rd = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx_dev.sv
// Directed bench for serial_tx_dev: register map, 8N1 frame timing, FIFO overflow,
// back-to-back frames, irq, async reset, and parity frames when SERIAL_TX_PARITY_EN is set.
module tb_serial_tx_dev;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        txd;
  logic        irq;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  serial_tx_dev dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .wd   (wd),
    .rd   (rd),
    .txd  (txd),
    .irq  (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    we   = 1'b1;
    addr = a;
    wd   = d;
    @(posedge clk);
    #1;
    we   = 1'b0;
    wd   = '0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    write_reg(2'd2, {24'h0, b});
    if (accept) exp_q.push_back(b);
  endtask

  // Checks one whole frame cycle by cycle, starting at the current sample point.
  task automatic expect_frame(input int div, input bit pen, input bit odd, input logic exp_irq);
    logic [7:0]  b;
    logic [10:0] bits;
    logic        obs;
    int          nb;
    int          busy_bad = 0;
    int          irq_bad  = 0;
    if (exp_q.size() == 0) begin
      check("scoreboard underflow", 32'd0, 32'd1);
      return;
    end
    b         = exp_q.pop_front();
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    if (pen) bits[9] = (^b) ^ odd;
    nb = pen ? 11 : 10;
    addr = 2'd1;
    #1;
    for (int i = 0; i < nb; i++) begin
      obs = bits[i];
      for (int c = 0; c <= div; c++) begin
        if (txd !== bits[i]) obs = txd;
        if (rd[0] !== 1'b1) busy_bad++;
        if (irq !== exp_irq) irq_bad++;
        @(posedge clk);
        #1;
      end
      check($sformatf("frame %02h bit %0d", b, i), {31'h0, obs}, {31'h0, bits[i]});
    end
    check($sformatf("frame %02h busy", b), busy_bad, 0);
    check($sformatf("frame %02h irq", b), irq_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          hi_bad;

    rst  = 1'b1;
    we   = 1'b0;
    addr = 2'd0;
    wd   = '0;
    step(3);
    @(negedge clk);
    rst = 1'b0;
    step(1);

    check("rst txd", {31'h0, txd}, 32'd1);
    check("rst irq", {31'h0, irq}, 32'd0);
    read_reg(2'd1, d); check("rst status", d, 32'h4);
    read_reg(2'd3, d); check("rst baud", d, 32'd15);
    read_reg(2'd0, d); check("rst ctrl", d, 32'h0);
    read_reg(2'd2, d); check("txdata reads 0", d, 32'h0);

    // Single 0x55 frame at BAUD=3
    write_reg(2'd3, 32'hABCD_0003);
    read_reg(2'd3, d); check("baud upper bits", d, 32'd3);
    write_reg(2'd0, 32'h1);
    push_byte(8'h55, 1'b1);
    check("txd before pop", {31'h0, txd}, 32'd1);
    step(1);
    expect_frame(3, 1'b0, 1'b0, 1'b0);
    read_reg(2'd1, d); check("status after frame", d, 32'h4);
    check("txd idle after frame", {31'h0, txd}, 32'd1);

    // Overflow with EN=0, then back-to-back drain
    write_reg(2'd0, 32'h0);
    push_byte(8'h11, 1'b1);
    push_byte(8'h12, 1'b1);
    push_byte(8'h13, 1'b1);
    push_byte(8'h14, 1'b1);
    push_byte(8'h15, 1'b0);
    push_byte(8'h16, 1'b0);
    read_reg(2'd1, d); check("status full ovf", d, 32'h4A);
    write_reg(2'd0, 32'h1);
    read_reg(2'd1, d); check("ovf cleared by ctrl", d, 32'h42);
    step(1);
    for (int k = 0; k < 4; k++) expect_frame(3, 1'b0, 1'b0, 1'b0);
    read_reg(2'd1, d); check("status after burst", d, 32'h4);

    // irq behaviour
    write_reg(2'd0, 32'h3);
    check("irq latency 0", {31'h0, irq}, 32'd0);
    step(1);
    check("irq asserted", {31'h0, irq}, 32'd1);
    push_byte(8'hA5, 1'b1);
    check("irq before pop", {31'h0, irq}, 32'd1);
    step(1);
    expect_frame(3, 1'b0, 1'b0, 1'b0);
    check("irq at frame end", {31'h0, irq}, 32'd0);
    step(1);
    check("irq after drain", {31'h0, irq}, 32'd1);

    // Async reset in the middle of a frame
    push_byte(8'h00, 1'b0);
    push_byte(8'h33, 1'b0);
    step(9);
    check("mid data txd", {31'h0, txd}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async rst txd", {31'h0, txd}, 32'd1);
    check("async rst irq", {31'h0, irq}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    step(1);
    read_reg(2'd1, d); check("status after rst", d, 32'h4);
    write_reg(2'd0, 32'h1);
    hi_bad = 0;
    repeat (50) begin
      if (txd !== 1'b1) hi_bad++;
      step(1);
    end
    check("no frame after rst", hi_bad, 0);
    read_reg(2'd1, d); check("fifo discarded", d, 32'h4);

    // Shortest bit period
    write_reg(2'd3, 32'h0);
    push_byte(8'hC3, 1'b1);
    step(1);
    expect_frame(0, 1'b0, 1'b0, 1'b0);
    check("txd idle after fast frame", {31'h0, txd}, 32'd1);

`ifdef SERIAL_TX_PARITY_EN
    write_reg(2'd3, 32'd3);
    write_reg(2'd0, 32'h5);
    push_byte(8'h07, 1'b1);
    step(1);
    expect_frame(3, 1'b1, 1'b0, 1'b0);
    write_reg(2'd0, 32'hD);
    read_reg(2'd0, d); check("ctrl parity readback", d, 32'hD);
    push_byte(8'h07, 1'b1);
    step(1);
    expect_frame(3, 1'b1, 1'b1, 1'b0);
    check("txd idle after parity", {31'h0, txd}, 32'd1);
`else
    write_reg(2'd0, 32'hD);
    read_reg(2'd0, d); check("ctrl parity bits masked", d, 32'h1);
`endif

    check("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
